fdiv_issue: RTL and testbench



---
 rtl/fdiv_pkg.sv | 16 +
 rtl/fdiv_if.sv | 26 ++
 rtl/fdiv_fifo.sv | 45 ++++
 rtl/fdiv_issue.sv | 140 ++++++++++++++
 tb/tb_fdiv_issue.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared types for the FP32 divider issue/return slice.
// Holds the issue FSM state encoding and FP32 special values.
package fdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        CAPT
    } fdiv_state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

endpackage

// File: rtl/fdiv_if.sv
// fdiv_if: operand request stream plus result return stream.
// master = producer/consumer side, slave = the issue stage.
interface fdiv_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_z;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag, out_err
    );
endinterface

// File: rtl/fdiv_fifo.sv
// fdiv_fifo: circular operand buffer, DEPTH entries of W bits.
// Ports: clk/rst, push+wdata, pop, rdata (head, no bypass), count.
module fdiv_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + P_ONE;
            if (pop)  rd_ptr <= rd_ptr + P_ONE;
            case ({push, pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fdiv_issue.sv
// fdiv_issue: buffers operand pairs, launches one divide at a time,
// returns quotient+tag. Ports: clk/rst, io (fdiv_if.slave), div_* to divider.
module fdiv_issue
    import fdiv_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int TAG_W        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    fdiv_if.slave       io,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_start,
    output logic        div_enable,
    input  logic        div_busy,
    input  logic [31:0] div_z
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int EW = 64 + TAG_W;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE = TW'(1);

    fdiv_state_t      state, state_n;
    logic [CW-1:0]    fifo_count;
    logic [EW-1:0]    head;
    logic             push, pop, capt, err_set, err_pend;
    logic             slot_free;
    logic [TW-1:0]    timer, timer_n;
    logic [TAG_W-1:0] op_tag;
    logic             out_valid_q, out_err_q;
    logic [31:0]      out_z_q;
    logic [TAG_W-1:0] out_tag_q;

    // ready is held low while reset is asserted
    assign io.in_ready = ~rst & (fifo_count < FULL);
    assign push        = io.in_valid & io.in_ready;
    assign slot_free   = ~out_valid_q | io.out_ready;

    assign io.out_valid = out_valid_q;
    assign io.out_z     = out_z_q;
    assign io.out_tag   = out_tag_q;
    assign io.out_err   = out_err_q;

    fdiv_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({io.in_tag, io.in_a, io.in_b}),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count)
    );

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        pop        = 1'b0;
        capt       = 1'b0;
        err_set    = 1'b0;
        div_start  = 1'b0;
        div_enable = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                div_start  = 1'b1;
                div_enable = 1'b1;
                timer_n    = '0;
                state_n    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                div_enable = 1'b1;
                if (div_busy) begin
                    state_n = WAIT_DONE;
                end else if (timer == TLAST) begin
                    err_set = 1'b1;
                    state_n = CAPT;
                end else begin
                    timer_n = timer + T_ONE;
                end
            end
            WAIT_DONE: begin
                div_enable = 1'b1;
                if (!div_busy) state_n = CAPT;
            end
            CAPT: begin
                // enable stays low so the divider result is frozen here
                if (slot_free) begin
                    capt    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            err_pend    <= 1'b0;
            div_a       <= '0;
            div_b       <= '0;
            op_tag      <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            if (pop) begin
                op_tag <= head[EW-1:64];
                div_a  <= head[63:32];
                div_b  <= head[31:0];
            end
            if (err_set) begin
                err_pend <= 1'b1;
            end else if (capt) begin
                err_pend <= 1'b0;
            end
            if (capt) begin
                out_valid_q <= 1'b1;
                out_z_q     <= div_z;
                out_tag_q   <= op_tag;
                out_err_q   <= err_pend;
            end else if (io.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fdiv_issue.sv
// tb_fdiv_issue: directed bench for fdiv_issue with a stub divider.
// Table-driven single ops plus backpressure, timeout, reset, stream sequences.
module tb_fdiv_issue;
    import fdiv_pkg::*;

    localparam int N = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] div_a, div_b;
    logic        div_start, div_enable;
    logic        div_busy = 1'b0;
    logic [31:0] div_z = 32'h0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fdiv_if #(.TAG_W(4)) bus ();

    fdiv_issue #(.DEPTH(4), .TAG_W(4), .BUSY_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (bus),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_start  (div_start),
        .div_enable (div_enable),
        .div_busy   (div_busy),
        .div_z      (div_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] stub_q(input logic [31:0] a, input logic [31:0] b);
        if (b[30:0] == 31'h0) begin
            if (a[30:0] == 31'h0) return QNAN;
            return {a[31] ^ b[31], 31'h7F80_0000};
        end
        case ({a, b})
            {32'h40C0_0000, 32'h4000_0000}: return 32'h4040_0000;
            {32'h4080_0000, 32'h4000_0000}: return 32'h4000_0000;
            {32'h4120_0000, 32'h40A0_0000}: return 32'h4000_0000;
            {32'hBF80_0000, 32'h4000_0000}: return 32'hBF00_0000;
            default: return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    // stub divider: busy for N cycles after a start pulse
    bit nobusy = 1'b0;
    int bcnt   = 0;
    always @(posedge clk) begin
        if (rst) begin
            div_busy <= 1'b0;
            bcnt     <= 0;
        end else if (div_start && div_enable) begin
            div_z <= stub_q(div_a, div_b);
            if (!nobusy) begin
                div_busy <= 1'b1;
                bcnt     <= N - 1;
            end
        end else if (div_busy) begin
            if (bcnt == 0) div_busy <= 1'b0;
            else bcnt <= bcnt - 1;
        end
    end

    typedef struct {
        int          cyc;
        logic [3:0]  tag;
        logic [31:0] z;
        logic        err;
    } xfer_t;

    xfer_t       mon_q[$];
    int          st_cyc = -1;
    logic [31:0] st_a = 0, st_b = 0;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            mon_q.push_back('{cyc, bus.out_tag, bus.out_z, bus.out_err});
        if (!rst && div_start) begin
            st_cyc = cyc;
            st_a   = div_a;
            st_b   = div_b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, output int acc);
        int n = 0;
        acc = -1;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        while (n < 200) begin
            if (bus.in_ready) begin
                acc = cyc;
                step();
                break;
            end
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL push_timeout tag=%0d got=no_accept exp=accept", tag);
        end
    endtask

    task automatic wait_out(input int bound, output int c);
        int n = 0;
        c = -1;
        while (n < bound) begin
            if (bus.out_valid) begin
                c = cyc;
                break;
            end
            step();
            n++;
        end
        if (c < 0) begin
            checks++;
            failures++;
            $display("FAIL out_timeout got=no_valid exp=valid");
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] z;
    } vec_t;

    vec_t tv[6];

    initial begin
        int acc, c, lat, pp_seen, n_pushed, guard;
        int accs[6];
        logic pp, ok;
        logic [31:0] ra, rb;
        logic [3:0] rt;
        logic [35:0] exp_q[$];

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        tv[0] = '{32'h40C0_0000, 32'h4000_0000, 4'd3,  32'h4040_0000};
        tv[1] = '{32'h3F80_0000, 32'h0000_0000, 4'd5,  32'h7F80_0000};
        tv[2] = '{32'h0000_0000, 32'h0000_0000, 4'd6,  32'h7FC0_0000};
        tv[3] = '{32'h4080_0000, 32'h4000_0000, 4'd1,  32'h4000_0000};
        tv[4] = '{32'h4120_0000, 32'h40A0_0000, 4'd2,  32'h4000_0000};
        tv[5] = '{32'hBF80_0000, 32'h4000_0000, 4'd15, 32'hBF00_0000};

        // reset state
        step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_div_enable", div_enable, 0);
        check("rst_div_start", div_start, 0);
        check("rst_div_a", div_a, 0);
        check("rst_out_tag_err_z", {bus.out_tag, bus.out_err, bus.out_z}, 0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", bus.in_ready, 1);

        // table-driven single ops from an empty, idle block
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_op(tv[i].a, tv[i].b, tv[i].tag, acc);
            wait_out(60, c);
            check($sformatf("lat_%0d", i), c - acc, 10);
            check($sformatf("start_%0d", i), st_cyc - acc, 2);
            check($sformatf("div_ab_%0d", i), {st_a, st_b}, {tv[i].a, tv[i].b});
            check($sformatf("z_%0d", i), bus.out_z, tv[i].z);
            check($sformatf("tag_%0d", i), bus.out_tag, tv[i].tag);
            check($sformatf("err_%0d", i), bus.out_err, 0);
            if (i == 2) begin
                c = int'(bus.out_z[30:23]);
                check("nan_exp", c, 8'hFF);
                check("nan_frac_nz", bus.out_z[22:0] != 23'h0, 1);
            end
            step();
        end

        // fill with output stalled
        bus.out_ready = 1'b0;
        mon_q.delete();
        for (int i = 0; i < 5; i++)
            push_op(32'h4000_0000 + i, 32'h3F80_0000, 4'(i), accs[i]);
        check("bp_consec", accs[4] - accs[0], 4);
        check("bp_ready_drop", bus.in_ready, 0);
        push_op(32'h4000_0005, 32'h3F80_0000, 4'd5, accs[5]);
        for (int i = 0; i < 20; i++) step();
        check("bp_full", bus.in_ready, 0);
        check("bp_held", {bus.out_valid, bus.out_tag}, {1'b1, 4'd0});
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && mon_q.size() < 6; i++) step();
        check("bp_count", mon_q.size(), 6);
        if (mon_q.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("bp_tag_%0d", i), mon_q[i].tag, i);
            for (int i = 2; i < 6; i++)
                check($sformatf("bp_gap_%0d", i), mon_q[i].cyc - mon_q[i-1].cyc, N + 4);
        end
        step();

        // busy never rises
        nobusy = 1'b1;
        push_op(32'h4080_0000, 32'h4000_0000, 4'd9, acc);
        wait_out(60, c);
        lat = c - st_cyc;
        checks++;
        if (!(lat >= 5 && lat <= 6)) begin
            failures++;
            $display("FAIL to_lat got=%0d exp=5..6", lat);
        end
        check("to_err", bus.out_err, 1);
        check("to_tag", bus.out_tag, 9);
        step();
        nobusy = 1'b0;
        push_op(32'h40C0_0000, 32'h4000_0000, 4'd10, acc);
        wait_out(60, c);
        check("to_next_lat", c - acc, 10);
        check("to_next", {bus.out_err, bus.out_tag, bus.out_z}, {1'b0, 4'd10, 32'h4040_0000});
        step();

        // reset while waiting on the divider with two ops queued
        push_op(32'h4080_0000, 32'h4000_0000, 4'd11, acc);
        push_op(32'h4080_0000, 32'h4000_0000, 4'd12, acc);
        push_op(32'h4080_0000, 32'h4000_0000, 4'd13, acc);
        for (int i = 0; i < 50 && !div_busy; i++) step();
        check("mr_busy_seen", div_busy, 1);
        step();
        step();
        mon_q.delete();
        rst = 1'b1;
        step();
        check("mr_enable", div_enable, 0);
        check("mr_count", dut.fifo_count, 0);
        check("mr_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        step();
        check("mr_ready_back", bus.in_ready, 1);
        c = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) c++;
            step();
        end
        check("mr_no_out", c + mon_q.size(), 0);
        push_op(32'h4120_0000, 32'h40A0_0000, 4'd14, acc);
        wait_out(60, c);
        check("mr_new_lat", c - acc, 10);
        check("mr_new", {bus.out_err, bus.out_tag, bus.out_z}, {1'b0, 4'd14, 32'h4000_0000});
        step();

        // sustained stream, pushes timed to coincide with pops at count 3
        mon_q.delete();
        pp_seen  = 0;
        n_pushed = 0;
        guard    = 0;
        ra = '0; rb = '0; rt = '0;
        while ((n_pushed < 100 || mon_q.size() < 100) && guard < 3000) begin
            if (n_pushed < 100 && (dut.fifo_count < 3 || bus.out_valid)) begin
                ra = $urandom;
                rb = $urandom;
                rt = 4'($urandom_range(0, 15));
                bus.in_valid = 1'b1;
                bus.in_a     = ra;
                bus.in_b     = rb;
                bus.in_tag   = rt;
            end else begin
                bus.in_valid = 1'b0;
            end
            ok = bus.in_valid && bus.in_ready;
            pp = ok && bus.out_valid && (dut.fifo_count == 3);
            step();
            if (ok) begin
                exp_q.push_back({rt, stub_q(ra, rb)});
                n_pushed++;
            end
            if (pp) begin
                pp_seen++;
                check("pp_count_hold", dut.fifo_count, 3);
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        check("pp_events", pp_seen >= 50, 1);
        check("sb_count", mon_q.size(), 100);
        if (mon_q.size() == 100 && exp_q.size() == 100)
            for (int i = 0; i < 100; i++)
                check($sformatf("sb_%0d", i), {mon_q[i].tag, mon_q[i].z}, exp_q[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end
endmodule
